// File: rtl/des_key_loader_pkg.sv
// Shared DES key-path definitions: widths, loader state encoding and a
// key parity helper.
package des_key_loader_pkg;

  localparam int KEY_W   = 64;
  localparam int WORD_W  = 32;
  localparam int SCHED_W = 768;
  localparam int RKEY_W  = 48;

  typedef enum logic [2:0] {
    S_WORD0  = 3'd0,
    S_WORD1  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // DES keys carry odd parity in every byte (bit 0 of each byte is the parity bit).
  function automatic logic des_key_parity_ok(input logic [KEY_W-1:0] key);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < KEY_W / 8; i++) begin
      ok = ok & (^key[i*8 +: 8]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/des_parity_check.sv
// Per-byte odd-parity flags for a 64-bit DES key plus an all-bytes-good summary.
module des_parity_check
  import des_key_loader_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  output logic [7:0]       byte_odd,
  output logic             all_ok
);

  for (genvar i = 0; i < 8; i++) begin : g_byte
    assign byte_odd[i] = ^key[i*8 +: 8];
  end

  assign all_ok = des_key_parity_ok(key);

endmodule

// File: rtl/des_key_loader.sv
// DES key loader: collects a 64-bit key in two words, checks parity, launches
// the round-key generator and holds the captured schedule for the datapath.
//
// state   | meaning
// --------+-------------------------------------------------------------
// WORD0   | idle, waiting for key[63:32] and mode
// WORD1   | waiting for key[31:0]; parity evaluated on accept
// LAUNCH  | one-cycle launch pulse to the generator
// WAIT    | waiting for generator valid, bounded by MAX_WAIT cycles
// DONE    | schedule captured and held; a new first word restarts
module des_key_loader
  import des_key_loader_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b1,
  parameter int MAX_WAIT     = 64,
  parameter int CNT_W        = 7
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [WORD_W-1:0]   key_word_i,
  input  logic                key_word_valid_i,
  output logic                key_word_ready_o,
  input  logic                encrypt_decrypt_i,
  output logic [KEY_W-1:0]    kg_init_key_o,
  output logic                kg_encrypt_decrypt_o,
  output logic                kg_valid_o,
  input  logic                kg_valid_i,
  input  logic [SCHED_W-1:0]  kg_round_keys_i,
  output logic [SCHED_W-1:0]  round_keys_o,
  output logic                keys_ready_o,
  output logic                parity_err_o,
  output logic                timeout_err_o,
  output logic                busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t              state;
  logic [WORD_W-1:0]   key_hi;
  logic                mode;
  logic [CNT_W-1:0]    cnt;
  logic [KEY_W-1:0]    key_full;
  logic [7:0]          byte_odd;
  logic                key_ok;
  logic                accept;

  assign key_full = {key_hi, key_word_i};

  des_parity_check u_parity (
    .key      (key_full),
    .byte_odd (byte_odd),
    .all_ok   (key_ok)
  );

  // Ready is gated by reset so no word is taken while the loader is held in reset.
  assign key_word_ready_o = rstn &&
                            (state == S_WORD0 || state == S_WORD1 || state == S_DONE);
  assign accept = key_word_valid_i && key_word_ready_o;
  assign busy_o = (state == S_WORD1) || (state == S_LAUNCH) || (state == S_WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= S_WORD0;
      key_hi               <= '0;
      mode                 <= 1'b0;
      cnt                  <= '0;
      kg_init_key_o        <= '0;
      kg_encrypt_decrypt_o <= 1'b0;
      kg_valid_o           <= 1'b0;
      round_keys_o         <= '0;
      keys_ready_o         <= 1'b0;
      parity_err_o         <= 1'b0;
      timeout_err_o        <= 1'b0;
    end else begin
      kg_valid_o <= 1'b0;
      case (state)
        S_WORD0, S_DONE: begin
          if (accept) begin
            key_hi        <= key_word_i;
            mode          <= encrypt_decrypt_i;
            parity_err_o  <= 1'b0;
            timeout_err_o <= 1'b0;
            keys_ready_o  <= 1'b0;
            state         <= S_WORD1;
          end
        end
        S_WORD1: begin
          if (accept) begin
            if (CHECK_PARITY && !key_ok) begin
              parity_err_o <= 1'b1;
              state        <= S_WORD0;
            end else begin
              kg_init_key_o        <= key_full;
              kg_encrypt_decrypt_o <= mode;
              kg_valid_o           <= 1'b1;
              state                <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          cnt <= '0;
          // A combinational generator answers in the launch cycle itself.
          if (kg_valid_i) begin
            round_keys_o <= kg_round_keys_i;
            keys_ready_o <= 1'b1;
            state        <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (kg_valid_i) begin
            round_keys_o <= kg_round_keys_i;
            keys_ready_o <= 1'b1;
            state        <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            timeout_err_o <= 1'b1;
            state         <= S_WORD0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_WORD0;
      endcase
    end
  end

  // The per-byte flags and the packaged helper must always agree.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (key_ok == (&byte_odd));
    end
  end

endmodule

// File: tb/tb_des_key_loader.sv
// Directed self-checking bench for des_key_loader with a latency-3 stub
// generator (dut_a) and a combinational stub generator (dut_b).
module tb_des_key_loader;
  import des_key_loader_pkg::*;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY2 = 64'h0101010101010101;
  localparam logic [63:0] KEY0 = 64'h0000000000000000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] key_word = '0;
  logic        enc = 1'b0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;

  logic         ready_a, kgv_o_a, kge_a, kgv_i_a, kr_a, perr_a, terr_a, busy_a;
  logic [63:0]  kgk_a;
  logic [767:0] rk_in_a, rk_a;
  logic         ready_b, kgv_o_b, kge_b, kgv_i_b, kr_b, perr_b, terr_b, busy_b;
  logic [63:0]  kgk_b;
  logic [767:0] rk_in_b, rk_b;

  des_key_loader #(.CHECK_PARITY(1'b1), .MAX_WAIT(8), .CNT_W(4)) dut_a (
    .clk(clk), .rstn(rstn), .key_word_i(key_word), .key_word_valid_i(valid_a),
    .key_word_ready_o(ready_a), .encrypt_decrypt_i(enc), .kg_init_key_o(kgk_a),
    .kg_encrypt_decrypt_o(kge_a), .kg_valid_o(kgv_o_a), .kg_valid_i(kgv_i_a),
    .kg_round_keys_i(rk_in_a), .round_keys_o(rk_a), .keys_ready_o(kr_a),
    .parity_err_o(perr_a), .timeout_err_o(terr_a), .busy_o(busy_a)
  );

  des_key_loader #(.CHECK_PARITY(1'b0), .MAX_WAIT(8), .CNT_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .key_word_i(key_word), .key_word_valid_i(valid_b),
    .key_word_ready_o(ready_b), .encrypt_decrypt_i(enc), .kg_init_key_o(kgk_b),
    .kg_encrypt_decrypt_o(kge_b), .kg_valid_o(kgv_o_b), .kg_valid_i(kgv_i_b),
    .kg_round_keys_i(rk_in_b), .round_keys_o(rk_b), .keys_ready_o(kr_b),
    .parity_err_o(perr_b), .timeout_err_o(terr_b), .busy_o(busy_b)
  );

  // Stub A: registered generator, latency 3, schedule = key replicated 12 times.
  logic [2:0]  sh = '0;
  logic [63:0] stub_key = '0;
  logic        stub_dead = 1'b0;
  logic        stub_force = 1'b0;
  always @(posedge clk) begin
    sh <= {sh[1:0], kgv_o_a};
    if (kgv_o_a) stub_key <= kgk_a;
  end
  assign kgv_i_a = !stub_dead && (sh[2] || stub_force);
  assign rk_in_a = stub_force ? {768{1'b1}} : {12{stub_key}};

  // Stub B: combinational generator, schedule = inverted key replicated.
  assign kgv_i_b = kgv_o_b;
  assign rk_in_b = {12{~kgk_b}};

  int cyc = 0;
  int launches_a = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (kgv_o_a) launches_a <= launches_a + 1;
  end

  int errors = 0;
  int checks = 0;
  int t0 = 0;

  task automatic drive_key(input logic [63:0] k, input logic e, input logic to_b);
    @(negedge clk);
    key_word = k[63:32];
    enc = e;
    if (to_b) valid_b = 1'b1; else valid_a = 1'b1;
    t0 = cyc;
    @(negedge clk);
    key_word = k[31:0];
    enc = ~e;  // mode must come from the first beat only
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic wait_ready(input logic sel, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if ((sel ? kr_b : kr_a) === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ready_a, kgv_o_a, kge_a, kr_a, perr_a, terr_a, busy_a} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b expected 0000000",
                         {ready_a, kgv_o_a, kge_a, kr_a, perr_a, terr_a, busy_a});
    end
    checks++;
    if (rk_a !== '0 || kgk_a !== '0) begin
      errors++; $display("FAIL reset_data got key=%h expected 0", kgk_a);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL reset_release got ready=%b busy=%b expected 1 0", ready_a, busy_a);
    end
  endtask

  task automatic test_basic_load();
    int l0, lat;
    l0 = launches_a;
    drive_key(KEY1, 1'b1, 1'b0);
    checks++;
    if (kgv_o_a !== 1'b1 || kgk_a !== KEY1 || kge_a !== 1'b1) begin
      errors++; $display("FAIL launch got v=%b key=%h mode=%b expected 1 %h 1", kgv_o_a, kgk_a, kge_a, KEY1);
    end
    checks++;
    if (busy_a !== 1'b1 || ready_a !== 1'b0) begin
      errors++; $display("FAIL launch_busy got busy=%b ready=%b expected 1 0", busy_a, ready_a);
    end
    wait_ready(1'b0, lat);
    checks++;
    if (lat != 6) begin
      errors++; $display("FAIL basic_latency got %0d expected 6", lat);
    end
    checks++;
    if (rk_a !== {12{KEY1}}) begin
      errors++; $display("FAIL basic_round_keys got %h expected %h", rk_a[767:704], KEY1);
    end
    checks++;
    if (perr_a !== 1'b0 || launches_a - l0 != 1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL basic_status got perr=%b launches=%0d busy=%b expected 0 1 0",
                         perr_a, launches_a - l0, busy_a);
    end
  endtask

  task automatic test_parity();
    int l0, lat;
    l0 = launches_a;
    drive_key(KEY0, 1'b1, 1'b0);
    checks++;
    if (perr_a !== 1'b1 || kgv_o_a !== 1'b0 || busy_a !== 1'b0 || ready_a !== 1'b1) begin
      errors++; $display("FAIL parity_reject got perr=%b v=%b busy=%b ready=%b expected 1 0 0 1",
                         perr_a, kgv_o_a, busy_a, ready_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (launches_a != l0 || kr_a !== 1'b0 || rk_a !== {12{KEY1}}) begin
      errors++; $display("FAIL parity_no_launch got launches=%0d ready=%b expected 0 0", launches_a - l0, kr_a);
    end
    drive_key(KEY0, 1'b1, 1'b1);
    checks++;
    if (kgv_o_b !== 1'b1 || kgk_b !== KEY0 || kr_b !== 1'b0) begin
      errors++; $display("FAIL comb_launch got v=%b key=%h ready=%b expected 1 0 0", kgv_o_b, kgk_b, kr_b);
    end
    wait_ready(1'b1, lat);
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL comb_latency got %0d expected 3", lat);
    end
    checks++;
    if (rk_b !== {768{1'b1}} || perr_b !== 1'b0) begin
      errors++; $display("FAIL comb_capture got rk=%h perr=%b expected ffff... 0", rk_b[767:704], perr_b);
    end
  endtask

  task automatic test_timeout();
    int lat;
    stub_dead = 1'b1;
    drive_key(KEY1, 1'b1, 1'b0);
    checks++;
    if (perr_a !== 1'b0) begin
      errors++; $display("FAIL parity_clear got %b expected 0", perr_a);
    end
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (terr_a === 1'b1) begin lat = cyc - t0; break; end
      @(negedge clk);
    end
    checks++;
    if (lat != 11) begin
      errors++; $display("FAIL timeout_latency got %0d expected 11", lat);
    end
    checks++;
    if (kr_a !== 1'b0 || busy_a !== 1'b0 || rk_a !== {12{KEY1}}) begin
      errors++; $display("FAIL timeout_state got ready=%b busy=%b expected 0 0", kr_a, busy_a);
    end
    stub_dead = 1'b0;
    drive_key(KEY1, 1'b1, 1'b0);
    checks++;
    if (terr_a !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got %b expected 0", terr_a);
    end
    wait_ready(1'b0, lat);
    checks++;
    if (lat != 6) begin
      errors++; $display("FAIL reload_after_timeout got %0d expected 6", lat);
    end
  endtask

  task automatic test_reload();
    int lat;
    @(negedge clk);
    key_word = KEY2[63:32];
    enc = 1'b0;
    valid_a = 1'b1;
    t0 = cyc;
    @(negedge clk);
    checks++;
    if (kr_a !== 1'b0 || rk_a !== {12{KEY1}} || busy_a !== 1'b1) begin
      errors++; $display("FAIL reload_first_beat got ready=%b busy=%b expected 0 1", kr_a, busy_a);
    end
    key_word = KEY2[31:0];
    enc = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    checks++;
    if (kge_a !== 1'b0 || kgk_a !== KEY2 || kgv_o_a !== 1'b1 || rk_a !== {12{KEY1}}) begin
      errors++; $display("FAIL reload_launch got mode=%b key=%h v=%b expected 0 %h 1", kge_a, kgk_a, kgv_o_a, KEY2);
    end
    wait_ready(1'b0, lat);
    checks++;
    if (lat != 6 || rk_a !== {12{KEY2}}) begin
      errors++; $display("FAIL reload_capture got lat=%0d rk=%h expected 6 %h", lat, rk_a[767:704], KEY2);
    end
  endtask

  task automatic test_ignore_in_done();
    @(negedge clk);
    stub_force = 1'b1;
    repeat (2) @(negedge clk);
    stub_force = 1'b0;
    @(negedge clk);
    checks++;
    if (rk_a !== {12{KEY2}} || kr_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL done_ignore got rk=%h ready=%b expected %h 1", rk_a[767:704], kr_a, KEY2);
    end
  endtask

  task automatic test_reset_mid();
    int l0;
    drive_key(KEY1, 1'b1, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({ready_a, kgv_o_a, kge_a, kr_a, perr_a, terr_a, busy_a} !== 7'b0 ||
        rk_a !== '0 || kgk_a !== '0) begin
      errors++; $display("FAIL reset_mid got flags=%b key=%h expected 0000000 0",
                         {ready_a, kgv_o_a, kge_a, kr_a, perr_a, terr_a, busy_a}, kgk_a);
    end
    @(negedge clk);
    stub_force = 1'b1;
    rstn = 1'b1;
    l0 = launches_a;
    repeat (4) @(negedge clk);
    stub_force = 1'b0;
    checks++;
    if (kr_a !== 1'b0 || rk_a !== '0 || busy_a !== 1'b0 || ready_a !== 1'b1 || launches_a != l0) begin
      errors++; $display("FAIL reset_mid_release got ready=%b kr=%b busy=%b expected 1 0 0", ready_a, kr_a, busy_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_load();
    test_parity();
    test_timeout();
    test_reload();
    test_ignore_in_done();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
